// File: rtl/memory_bank_ctrl.sv
// Single-port memory bank with byte strobes, pipelined reads,
// post-reset clear sequence, collision policy and range check.
module memory_bank_ctrl #(
  parameter int Data_Width = 32,
  parameter int Addr_Width = 5,
  parameter int Depth      = 2**Addr_Width,
  parameter int Rd_Latency = 1,
  parameter int Rw_Mode    = 0,
  parameter logic [Data_Width-1:0] Init_Value = '0
) (
  input  logic                    CLK,
  input  logic                    Rst,
  input  logic                    Wr_En,
  input  logic                    Rd_En,
  input  logic [Data_Width/8-1:0] Byte_En,
  input  logic [Addr_Width-1:0]   Address,
  input  logic [Data_Width-1:0]   Data_in,
  output logic [Data_Width-1:0]   Data_out,
  output logic                    Valid_out,
  output logic                    Ready,
  output logic                    Err_out
);

  localparam int NB = Data_Width / 8;
  localparam logic [Addr_Width:0] DEPTH_W =
    (Addr_Width+1)'(Depth);
  localparam logic [Addr_Width-1:0] LAST =
    Addr_Width'(Depth - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [Addr_Width-1:0] cnt;
  logic [Data_Width-1:0] mem [Depth];

  logic in_range;
  logic wr_fire;
  logic rd_fire;
  logic bad;
  logic [Data_Width-1:0] old_word;
  logic [Data_Width-1:0] merged;
  logic [Data_Width-1:0] rd_word;

  // Stage 0 captures the word at the command edge; the
  // remaining Rd_Latency stages delay it to the output.
  logic [Rd_Latency:0]   pv;
  logic [Data_Width-1:0] pd [Rd_Latency+1];
  logic                  err_q;

  assign in_range = {1'b0, Address} < DEPTH_W;
  assign wr_fire  = Ready & Wr_En & in_range;
  assign rd_fire  = Ready & Rd_En & in_range;
  assign bad      = Ready & (Wr_En | Rd_En) & ~in_range;
  assign old_word = in_range ? mem[Address] : '0;

  // Byte-lane merge of the write data over the stored word.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (Byte_En[i]) begin
        merged[8*i +: 8] = Data_in[8*i +: 8];
      end
    end
  end

  // Collision policy: write-first returns the merged word.
  always_comb begin
    rd_word = old_word;
    if (Rw_Mode == 1 && Wr_En) begin
      rd_word = merged;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Ready decode.
  always_comb begin
    state_nxt = state;
    Ready     = 1'b0;
    unique case (state)
      INIT: begin
        if (cnt == LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        Ready = 1'b1;
      end
    endcase
  end

  // Clear-sequence word counter.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      cnt <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Storage: clear writes during INIT, strobed writes in RUN.
  always_ff @(posedge CLK) begin
    if (!Rst) begin
      if (state == INIT) begin
        mem[cnt] <= Init_Value;
      end else if (wr_fire) begin
        mem[Address] <= merged;
      end
    end
  end

  // Read pipeline; each stage holds its data until refilled,
  // so the last stage keeps Data_out between reads.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      pv <= '0;
      for (int i = 0; i <= Rd_Latency; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv <= {pv[Rd_Latency-1:0], rd_fire};
      if (rd_fire) begin
        pd[0] <= rd_word;
      end
      for (int i = 1; i <= Rd_Latency; i++) begin
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
        end
      end
    end
  end

  assign Data_out  = pd[Rd_Latency];
  assign Valid_out = pv[Rd_Latency];

  // Out-of-range flag, two stages to match read timing.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      err_q   <= 1'b0;
      Err_out <= 1'b0;
    end else begin
      err_q   <= bad;
      Err_out <= err_q;
    end
  end

endmodule
